// File: rtl/aes_key_schedule.sv
// AES key schedule for 128/192/256-bit keys: expands one word per cycle into a
// round-key store and serves any round key by index with one cycle of latency.
module aes_key_schedule #(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    input  logic [K-1:0]   i_key,
    output logic           o_busy,
    output logic           o_ready,
    input  logic           i_rd_en,
    input  logic [3:0]     i_rd_round,
    output logic [127:0]   o_rd_key,
    output logic           o_rd_valid,
    output logic           o_rd_err
);
    localparam int NK = K / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_k
            $error("aes_key_schedule: K must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [2:0]  r_mod;
    logic [7:0]  r_rcon;
    logic [31:0] r_w [NW];

    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic [31:0] w_new;
    logic [5:0]  w_rd_base;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    // Next schedule word; one SubWord serves both the rotate and the NK=8 mid-block case.
    always_comb begin
        w_prev   = r_w[r_idx - 6'd1];
        w_old    = r_w[r_idx - 6'(NK)];
        w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub    = sub_word(w_sub_in);
        if (r_mod == 3'd0) begin
            w_t = w_sub ^ {r_rcon, 24'h000000};
        end else if (NK == 8 && r_mod == 3'd4) begin
            w_t = w_sub;
        end else begin
            w_t = w_prev;
        end
        w_new     = w_old ^ w_t;
        w_rd_base = {i_rd_round, 2'b00};
    end

    // Control FSM: start always (re)loads, expansion runs until the last word is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 6'd0;
            r_mod   <= 3'd0;
            r_rcon  <= 8'h01;
            o_busy  <= 1'b0;
            o_ready <= 1'b0;
        end else if (i_start) begin
            r_state <= S_EXPAND;
            r_idx   <= 6'(NK);
            r_mod   <= 3'd0;
            r_rcon  <= 8'h01;
            o_busy  <= 1'b1;
            o_ready <= 1'b0;
        end else begin
            case (r_state)
                S_EXPAND: begin
                    r_idx <= r_idx + 6'd1;
                    r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
                    if (r_mod == 3'd0) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (r_idx == 6'(NW - 1)) begin
                        r_state <= S_READY;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Round-key store; contents are don't-care until a start reloads them.
    always_ff @(posedge clk) begin
        if (i_start) begin
            for (int i = 0; i < NK; i++) begin
                r_w[i] <= i_key[K-1-32*i -: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_w[r_idx] <= w_new;
        end
    end

    // Registered read port; a read coinciding with start sees the old store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rd_key   <= 128'd0;
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
        end else if (i_rd_en) begin
            if (o_ready && (i_rd_round <= 4'(NR))) begin
                o_rd_key   <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                               r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
                o_rd_valid <= 1'b1;
                o_rd_err   <= 1'b0;
            end else begin
                o_rd_key   <= 128'd0;
                o_rd_valid <= 1'b0;
                o_rd_err   <= 1'b1;
            end
        end else begin
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
        end
    end
endmodule
